// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
// Widths, reset PC, halt opcode and FSM state encoding.
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
  localparam logic [3:0] OPC_HALT = 4'hF;
  localparam logic [ADDR_W-1:0] PC_INC = 16'd2;

  typedef enum logic [1:0] {
    REQ,
    HOLD,
    DRAIN,
    HALT
  } fetch_state_t;

  // True when the opcode field selects HLT.
  function automatic logic is_halt(
    input logic [INSTR_W-1:0] instr
  );
    return instr[INSTR_W-1 -: 4] == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus.
// Master side is the fetch stage, slave side the memory.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic               imem_req_o;
  logic [ADDR_W-1:0]  imem_addr_o;
  logic               imem_ready_i;
  logic [INSTR_W-1:0] imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_data_i
  );

endinterface

// File: rtl/fetch_hold_reg.sv
// One-entry buffer for a response that arrived while decode stalled.
// Holds instruction and its PC; clear has priority over load.
module fetch_hold_reg
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               clr_i,
  input  logic [INSTR_W-1:0] data_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] data_o,
  output logic [ADDR_W-1:0]  pc_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] data_q;
  logic [ADDR_W-1:0]  pc_q;

  // Capture on load, drop on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: next-PC, single-outstanding imem requests,
// stall buffering, redirect draining and HLT detection.
module fetch_stage
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  fetch_stage_if.master      imem,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  output logic [ADDR_W-1:0]  pc_plus2_o,
  output logic               instr_valid_o,
  output logic               halted_o
);

  fetch_state_t       state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  drain_addr_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  ipc_q;
  logic [ADDR_W-1:0]  pc2_q;
  logic               valid_q;
  logic               halted_q;

  logic [ADDR_W-1:0]  pc_inc_d;
  logic [ADDR_W-1:0]  redir_pc_d;
  logic               rsp_halt;
  logic               hold_halt;
  logic               hold_load;
  logic               hold_clr;
  logic               hold_vld;
  logic [INSTR_W-1:0] hold_data;
  logic [ADDR_W-1:0]  hold_pc;
  logic               ready;

  assign ready      = imem.imem_ready_i;
  assign pc_inc_d   = pc_q + PC_INC;
  assign redir_pc_d = {redirect_pc_i[ADDR_W-1:1], 1'b0};
  assign rsp_halt   = is_halt(imem.imem_data_i);
  assign hold_halt  = is_halt(hold_data);

  assign hold_load = (state_q == REQ) && !redirect_i
                   && ready && stall_i;
  assign hold_clr  = redirect_i
                   || ((state_q == HOLD) && !stall_i);

  fetch_hold_reg u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (hold_load),
    .clr_i   (hold_clr),
    .data_i  (imem.imem_data_i),
    .pc_i    (pc_q),
    .valid_o (hold_vld),
    .data_o  (hold_data),
    .pc_o    (hold_pc)
  );

  // Request drops the instant reset asserts.
  assign imem.imem_req_o = rst_n
    && ((state_q == REQ) || (state_q == DRAIN));
  // DRAIN keeps presenting the abandoned address.
  assign imem.imem_addr_o = (state_q == DRAIN)
    ? drain_addr_q : pc_q;

  // Fetch FSM with PC and IF/ID output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      instr_q      <= '0;
      ipc_q        <= '0;
      pc2_q        <= '0;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      unique case (state_q)
        REQ: begin
          if (redirect_i) begin
            pc_q     <= redir_pc_d;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            if (!ready) begin
              state_q      <= DRAIN;
              drain_addr_q <= pc_q;
            end
          end else if (ready && !stall_i) begin
            instr_q <= imem.imem_data_i;
            ipc_q   <= pc_q;
            pc2_q   <= pc_inc_d;
            valid_q <= 1'b1;
            if (rsp_halt) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_inc_d;
            end
          end else if (ready) begin
            state_q <= HOLD;
            if (!rsp_halt) pc_q <= pc_inc_d;
          end else if (!stall_i) begin
            valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect_i) begin
            pc_q     <= redir_pc_d;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            state_q  <= REQ;
          end else if (!stall_i && hold_vld) begin
            instr_q <= hold_data;
            ipc_q   <= hold_pc;
            pc2_q   <= hold_pc + PC_INC;
            valid_q <= 1'b1;
            if (hold_halt) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= REQ;
            end
          end else if (!stall_i) begin
            state_q <= REQ;
          end
        end
        DRAIN: begin
          if (redirect_i) pc_q <= redir_pc_d;
          if (ready) state_q <= REQ;
        end
        HALT: begin
          if (redirect_i) begin
            pc_q     <= redir_pc_d;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            state_q  <= REQ;
          end else if (!stall_i) begin
            valid_q <= 1'b0;
          end
        end
        default: state_q <= REQ;
      endcase
    end
  end

  assign pc_o          = pc_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;
  assign pc_plus2_o    = pc2_q;
  assign instr_valid_o = valid_q;
  assign halted_o      = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a program-order
// stream model checked on every accepted instruction.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] pc, instr, ipc, pc2;
  logic        valid, halted;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem          (imem),
    .pc_o          (pc),
    .instr_o       (instr),
    .instr_pc_o    (ipc),
    .pc_plus2_o    (pc2),
    .instr_valid_o (valid),
    .halted_o      (halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string n,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic timeout_fail(input string n);
    total++;
    bad++;
    $display("FAIL %s timeout", n);
  endtask

  // Program image: overrides, else opcode 3 + low address bits.
  logic [15:0] mem_ovr [logic [15:0]];

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {4'h3, a[11:0]};
  endfunction

  // Memory: answers after `waits` idle request cycles.
  int waits = 0;
  int cnt = 0;
  initial begin
    imem.imem_ready_i = 1'b0;
    imem.imem_data_i  = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        imem.imem_ready_i = 1'b0;
        cnt = 0;
      end else begin
        #1;
        if (rst_n && imem.imem_req_o) begin
          if (cnt >= waits) begin
            imem.imem_ready_i = 1'b1;
            imem.imem_data_i  = mem_rd(imem.imem_addr_o);
            cnt = 0;
          end else begin
            imem.imem_ready_i = 1'b0;
            cnt++;
          end
        end else begin
          imem.imem_ready_i = 1'b0;
          cnt = 0;
        end
      end
    end
  end

  // Stream model: accepted instructions follow program order
  // from the last redirect, and nothing follows an HLT.
  logic [15:0] exp_pc = RESET_PC;
  bit          halt_seen = 0;
  bit          prev_wait = 0;
  logic [15:0] prev_addr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc    = RESET_PC;
      halt_seen = 0;
      prev_wait = 0;
    end else begin
      if (prev_wait && imem.imem_req_o)
        check("addr_stable", imem.imem_addr_o, prev_addr);
      prev_wait = imem.imem_req_o && !imem.imem_ready_i;
      prev_addr = imem.imem_addr_o;
      if (halt_seen) begin
        check("no_valid_after_halt", valid && !stall, 0);
        check("halted_flag", halted, 1);
      end else if (valid && !stall) begin
        check("stream_pc", ipc, exp_pc);
        check("stream_instr", instr, mem_rd(exp_pc));
        check("stream_pc2", pc2, 16'(exp_pc + 16'd2));
        if (mem_rd(exp_pc) >> 12 == 16'hF) halt_seen = 1;
        else exp_pc = 16'(exp_pc + 16'd2);
      end
      if (redirect) begin
        exp_pc    = {redirect_pc[15:1], 1'b0};
        halt_seen = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_redirect(input logic [15:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    tick();
    redirect = 1'b0;
  endtask

  logic [15:0] a;
  bit ok;

  initial begin
    mem_ovr[16'h0000] = 16'h1111;
    mem_ovr[16'h0002] = 16'h2222;
    mem_ovr[16'h0004] = 16'hABCD;
    mem_ovr[16'h0010] = 16'hF000;

    #12;
    check("rst_pc", pc, 16'h0000);
    check("rst_valid", valid, 0);
    check("rst_halted", halted, 0);
    check("rst_instr", instr, 0);
    check("rst_ipc", ipc, 0);
    check("rst_pc2", pc2, 0);
    check("rst_req", imem.imem_req_o, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Zero-wait streaming then a stall on the response at 4.
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pc == 16'h0004) begin ok = 1; break; end
    end
    if (!ok) timeout_fail("reach_pc4");
    check("zw_instr", instr, 16'h2222);
    check("zw_ipc", ipc, 16'h0002);
    stall = 1'b1;
    tick();
    check("hold_req", imem.imem_req_o, 0);
    check("hold_pc", pc, 16'h0006);
    check("hold_instr", instr, 16'h2222);
    tick();
    tick();
    check("hold_frozen", instr, 16'h2222);
    stall = 1'b0;
    tick();
    check("rel_instr", instr, 16'hABCD);
    check("rel_ipc", ipc, 16'h0004);
    check("rel_pc", pc, 16'h0006);
    check("rel_valid", valid, 1);

    // Two wait states: valid pattern 1,0,0,1.
    waits = 2;
    repeat (6) tick();
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid) begin ok = 1; break; end
      tick();
    end
    if (!ok) timeout_fail("ws_find_valid");
    a = imem.imem_addr_o;
    tick();
    check("ws_bubble1", valid, 0);
    check("ws_addr1", imem.imem_addr_o, a);
    tick();
    check("ws_bubble2", valid, 0);
    check("ws_addr2", imem.imem_addr_o, a);
    tick();
    check("ws_valid", valid, 1);
    check("ws_ipc", ipc, a);

    // Redirect while a request is pending.
    check("rd_pending", imem.imem_req_o && !imem.imem_ready_i, 1);
    do_redirect(16'h0041);
    check("rd_valid", valid, 0);
    check("rd_pc", pc, 16'h0040);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid) begin ok = 1; break; end
    end
    if (!ok) timeout_fail("rd_first");
    check("rd_first_ipc", ipc, 16'h0040);

    // HLT at 0x10.
    waits = 0;
    do_redirect(16'h000C);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (halted) begin ok = 1; break; end
    end
    if (!ok) timeout_fail("halt_reach");
    check("halt_pc", pc, 16'h0010);
    check("halt_instr", instr, 16'hF000);
    check("halt_ipc", ipc, 16'h0010);
    repeat (3) begin
      tick();
      check("halt_noreq", imem.imem_req_o, 0);
    end
    do_redirect(16'h0100);
    check("unhalt", halted, 0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid) begin ok = 1; break; end
    end
    if (!ok) timeout_fail("unhalt_first");
    check("unhalt_ipc", ipc, 16'h0100);

    // Wrap around the top of the address space.
    do_redirect(16'hFFFE);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid && ipc == 16'hFFFE) begin ok = 1; break; end
      tick();
    end
    if (!ok) timeout_fail("wrap_find");
    check("wrap_pc2", pc2, 16'h0000);
    check("wrap_instr", instr, 16'h3FFE);
    tick();
    check("wrap_next_ipc", ipc, 16'h0000);
    check("wrap_next_instr", instr, 16'h1111);
    check("wrap_next_pc2", pc2, 16'h0002);

    // Asynchronous reset during a wait.
    waits = 3;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem.imem_req_o && !imem.imem_ready_i) begin
        ok = 1; break;
      end
    end
    if (!ok) timeout_fail("ar_find_wait");
    rst_n = 1'b0;
    #1;
    check("ar_req", imem.imem_req_o, 0);
    check("ar_pc", pc, 16'h0000);
    check("ar_valid", valid, 0);
    check("ar_halted", halted, 0);
    check("ar_instr", instr, 0);
    check("ar_ipc", ipc, 0);
    check("ar_pc2", pc2, 0);
    tick();
    tick();
    waits = 0;
    rst_n = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid) begin ok = 1; break; end
    end
    if (!ok) timeout_fail("ar_restart");
    check("ar_first_ipc", ipc, 16'h0000);
    check("ar_first_instr", instr, 16'h1111);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the PC register and IF/ID boundary.
- Computes next PC (sequential +2 or redirect target) and drives the PC-register `next` input.
- Issues in-order single-outstanding requests to instruction memory; delivers instruction plus its PC to decode with a valid flag.
- Handles hazard stalls, branch/flush redirects and HLT detection.

Parameters:
- ADDR_W, 16, PC and memory address width
- INSTR_W, 16, instruction width
- RESET_PC, 16'h0000, fetch address after reset
- OPC_HALT, 4'hF, opcode (instr[15:12]) that stops fetch

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- stall_i  input  1  decode cannot accept; hold outputs
- redirect_i  input  1  branch taken / flush; highest priority
- redirect_pc_i  input  ADDR_W  redirect target; bit 0 forced to 0
- imem_req_o  output  1  memory request, held until imem_ready_i
- imem_addr_o  output  ADDR_W  request address (= pc_o while requesting)
- imem_ready_i  input  1  response valid this cycle (in-order)
- imem_data_i  input  INSTR_W  response data
- pc_o  output  ADDR_W  current fetch PC; feeds PC register next
- instr_o  output  INSTR_W  fetched instruction to decode
- instr_pc_o  output  ADDR_W  address of instr_o
- pc_plus2_o  output  ADDR_W  instr_pc_o + 2 (link value)
- instr_valid_o  output  1  instr_o valid
- halted_o  output  1  fetch stopped on HLT

Behaviour:
- Clock/reset: clk; rst_n asynchronous, active-low, as already decided.
- Reset values: pc_o=RESET_PC, state=REQ, instr_o=0, instr_pc_o=0, pc_plus2_o=0, instr_valid_o=0, halted_o=0, hold buffer empty. Reset mid-request abandons it; imem_req_o deasserts asynchronously.
- FSM states: REQ, HOLD, DRAIN, HALT.
- REQ
  - imem_req_o=1, imem_addr_o=pc_o.
  - On imem_ready_i with stall_i=0: next edge loads instr_o=imem_data_i, instr_pc_o=pc_o, pc_plus2_o=pc_o+2, instr_valid_o=1, pc_o<=pc_o+2. Stay in REQ, so a zero-wait memory gives 1 instr/cycle.
  - If imem_ready_i=0 and stall_i=0: instr_valid_o<=0 (bubble).
  - On imem_ready_i with stall_i=1: capture data and PC into the hold buffer, pc_o<=pc_o+2, go HOLD. Outputs unchanged.
- HOLD
  - imem_req_o=0; outputs frozen while stall_i=1.
  - When stall_i=0: buffer moves to outputs (valid=1), then go REQ, or HALT if the buffered opcode is OPC_HALT.
- Halt detect
  - A response with instr[15:12]==OPC_HALT is delivered normally. pc_o is NOT incremented (stays at the HLT address), state goes HALT.
- HALT
  - imem_req_o=0, halted_o=1; instr_valid_o clears once accepted (stall_i=0).
  - Exits only on redirect_i.
- stall_i with no ready pending: outputs hold, request continues.
- Redirect (all states, overrides stall)
  - Next edge: pc_o<=redirect_pc_i & ~1, instr_valid_o<=0, hold buffer cleared, halted_o<=0.
  - In REQ without simultaneous imem_ready_i: go DRAIN.
  - Otherwise, including ready in the same cycle (that response discarded): go REQ.
- DRAIN
  - imem_req_o stays 1 with the old address; waits for imem_ready_i, discards data, then goes REQ at the new pc_o.
  - A new redirect in DRAIN only updates pc_o.
- Arithmetic: all PC adds modulo 2^ADDR_W (16'hFFFE+2=16'h0000); no overflow flag.
- Invariant: imem_addr_o stable while imem_req_o=1 and imem_ready_i=0.

Decomposition:
- cpu_pkg: ADDR_W, INSTR_W, RESET_PC, OPC_HALT, fetch_state_t enum {REQ,HOLD,DRAIN,HALT}, PC_INC=2.
- One sub-module, fetch_hold_reg: one-entry data+PC buffer with load/clear/valid; the FSM and PC update stay in fetch_stage.

Test Plan:
- Reset, zero-wait memory returning 16'h1111 at 0, 16'h2222 at 2 -> instr_o 16'h1111/pc 0 then 16'h2222/pc 2 on consecutive cycles, pc_o=4.
- 2-wait memory -> imem_addr_o constant 2 cycles, instr_valid_o low during waits, one valid per response.
- stall_i=1 when ready at pc 4 (data 16'hABCD) -> outputs frozen, state HOLD, req low. Release -> instr_o=16'hABCD, instr_pc_o=4, pc_o=6.
- redirect_i to 16'h0041 during pending request -> DRAIN discards old response. Next fetch address 16'h0040; no stale valid.
- HLT 16'hF000 fetched at 16'h0010 -> delivered, halted_o=1, pc_o=16'h0010, no further requests. redirect to 16'h0100 resumes fetch at 16'h0100.
- pc_o=16'hFFFE with ready -> pc_o wraps to 16'h0000, pc_plus2_o=16'h0000. rst_n low mid-wait -> all outputs reset asynchronously.
